// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-granular round-robin arbiter feeding one UART transmitter
// The grant is held from a message's first byte to its last, pacing each byte through tx_start/tx_busy.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int IDLE_TO = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_start,
  input  logic                        tx_busy,
  output logic                        grant_active,
  output logic [2:0]                  grant_id,
  output logic                        msg_abort
);

  typedef enum logic [2:0] {IDLE, SEND, START, WAIT_HI, WAIT_LO} state_t;

  localparam int CNT_W = (IDLE_TO < 2) ? 1 : $clog2(IDLE_TO + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((IDLE_TO == 0) ? 0 : IDLE_TO - 1);

  state_t              state_q;
  logic [2:0]          ptr_q;
  logic [2:0]          grant_id_q;
  logic [DATA_W-1:0]   tx_data_q;
  logic                tx_start_q;
  logic                grant_active_q;
  logic                msg_abort_q;
  logic                last_q;
  logic [CNT_W-1:0]    idle_cnt_q;

  logic [NUM_REQ-1:0]  gnt_oh;
  logic                g_valid;
  logic                g_last;
  logic [DATA_W-1:0]   g_data;
  logic                pick_found;
  logic [2:0]          grant_id_d;
  logic [2:0]          ptr_d;
  logic                send_ok;
  logic                hs;

  // Route the granted requester's byte lane.
  always_comb begin
    gnt_oh  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == 3'(i)) begin
        gnt_oh[i] = 1'b1;
        g_valid   = req_valid[i];
        g_last    = req_last[i];
        g_data    = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // First valid requester at or above ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    grant_id_d = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!pick_found && req_valid[j] &&
            ((int'(ptr_q) + k == j) || (int'(ptr_q) + k == j + NUM_REQ))) begin
          pick_found = 1'b1;
          grant_id_d = 3'(j);
        end
      end
    end
  end

  assign ptr_d   = (grant_id_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id_q + 3'd1;
  assign send_ok = (state_q == SEND) && !tx_busy;
  assign hs      = send_ok && g_valid;

  assign req_ready    = gnt_oh & {NUM_REQ{send_ok}};
  assign tx_data      = tx_data_q;
  assign tx_start     = tx_start_q;
  assign grant_active = grant_active_q;
  assign grant_id     = grant_id_q;
  assign msg_abort    = msg_abort_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      grant_id_q     <= '0;
      tx_data_q      <= '0;
      tx_start_q     <= 1'b0;
      grant_active_q <= 1'b0;
      msg_abort_q    <= 1'b0;
      last_q         <= 1'b0;
      idle_cnt_q     <= '0;
    end else begin
      tx_start_q  <= 1'b0;
      msg_abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_id_q     <= grant_id_d;
            grant_active_q <= 1'b1;
            idle_cnt_q     <= '0;
            state_q        <= SEND;
          end
        end
        SEND: begin
          // A handshake takes precedence over a coincident timeout expiry.
          if (hs) begin
            tx_data_q  <= g_data;
            last_q     <= g_last;
            idle_cnt_q <= '0;
            tx_start_q <= 1'b1;
            state_q    <= START;
          end else if (!g_valid) begin
            if ((IDLE_TO != 0) && (idle_cnt_q == CNT_LAST)) begin
              msg_abort_q    <= 1'b1;
              grant_active_q <= 1'b0;
              ptr_q          <= ptr_d;
              idle_cnt_q     <= '0;
              state_q        <= IDLE;
            end else begin
              idle_cnt_q <= idle_cnt_q + CNT_W'(1);
            end
          end
        end
        START: state_q <= WAIT_HI;
        WAIT_HI: begin
          if (tx_busy) state_q <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            if (last_q) begin
              grant_active_q <= 1'b0;
              ptr_q          <= ptr_d;
              state_q        <= IDLE;
            end else begin
              state_q <= SEND;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
// Requester queues and a UART busy model drive the DUT; a transaction-level model checks it.
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int W        = 8;
  localparam int TO       = 5;
  localparam int BUSY_CYC = 10;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic           grant_active;
  logic [2:0]     grant_id;
  logic           msg_abort;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .IDLE_TO(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .grant_active (grant_active),
    .grant_id     (grant_id),
    .msg_abort    (msg_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Requester-side byte queues and UART model state
  logic [W-1:0] dq [N][$];
  logic         lq [N][$];
  int           gap [N];
  int           max_gap;
  int           busy_cnt;
  logic         force_busy;
  logic         frame_end_now;

  // Reference model state
  int           exp_ptr;
  int           cur_g;
  logic         prev_ga;
  logic [N-1:0] prev_valid;
  logic [N-1:0] hs_q;
  logic         pend_hs;
  logic         start_seen;
  logic [W-1:0] held_byte;
  logic         last_sent_last;
  logic         exp_release;
  logic         exp_ready;
  logic         abort_seen;
  int           n_starts;
  int           n_ready;
  int           gorder[$];
  logic [W-1:0] txlog[$];

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int total_queued();
    int s = 0;
    for (int i = 0; i < N; i++) s += dq[i].size();
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      dq[i].delete();
      lq[i].delete();
      gap[i] = 0;
    end
    busy_cnt = 0; force_busy = 1'b0; frame_end_now = 1'b0;
    exp_ptr = 0; cur_g = 0; prev_ga = 1'b0; prev_valid = '0; hs_q = '0;
    pend_hs = 1'b0; start_seen = 1'b0; held_byte = '0; last_sent_last = 1'b0;
    exp_release = 1'b0; exp_ready = 1'b0;
  endtask

  task automatic push_byte(input int r, input logic [W-1:0] b, input logic l);
    dq[r].push_back(b);
    lq[r].push_back(l);
  endtask

  task automatic push_msg(input int r, input int len);
    for (int k = 0; k < len; k++) push_byte(r, W'($urandom_range(0, 255)), k == len - 1);
  endtask

  task automatic drive();
    frame_end_now = 1'b0;
    if (start_seen) busy_cnt = BUSY_CYC;
    else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) frame_end_now = 1'b1;
    end
    tx_busy = force_busy || (busy_cnt > 0);
    for (int i = 0; i < N; i++) begin
      if (hs_q[i] && dq[i].size() > 0) begin
        void'(dq[i].pop_front());
        void'(lq[i].pop_front());
        gap[i] = $urandom_range(0, max_gap);
      end else if (gap[i] > 0) gap[i]--;
      req_valid[i]       = (dq[i].size() > 0) && (gap[i] == 0);
      req_data[i*W +: W] = (dq[i].size() > 0) ? dq[i][0] : '0;
      req_last[i]        = (lq[i].size() > 0) ? lq[i][0] : 1'b0;
    end
  endtask

  task automatic monitor();
    logic [N-1:0] gmask;
    int eg;
    if (grant_active && !prev_ga) begin
      eg = rr_pick(prev_valid, exp_ptr);
      check_eq("grant_id", 32'(grant_id), 32'(eg));
      cur_g = (eg >= 0) ? eg : int'(grant_id);
      gorder.push_back(int'(grant_id));
      last_sent_last = 1'b0;
      if (!tx_busy) check_eq("ready_after_grant", 32'(req_ready[cur_g]), 32'(1));
    end
    if (!grant_active && prev_ga) begin
      check_eq("end_abort", 32'(msg_abort), 32'(!last_sent_last));
      exp_ptr = (cur_g + 1) % N;
    end else begin
      check_eq("abort_idle", 32'(msg_abort), 32'(0));
    end
    if (exp_release) check_eq("release", 32'(grant_active), 32'(0));
    if (exp_ready) check_eq("ready_after_frame", 32'(req_ready[cur_g]), 32'(1));
    exp_release = 1'b0;
    exp_ready   = 1'b0;
    if (frame_end_now && grant_active) begin
      if (last_sent_last) exp_release = 1'b1;
      else if (!force_busy) exp_ready = 1'b1;
    end
    gmask = grant_active ? (N'(1) << cur_g) : '0;
    check_eq("ready_mask", 32'(req_ready & ~gmask), 32'(0));
    check_eq("ready_busy", 32'(req_ready & {N{tx_busy}}), 32'(0));
    check_eq("tx_start", 32'(tx_start), 32'(pend_hs));
    check_eq("start_busy", 32'(tx_start & tx_busy), 32'(0));
    check_eq("tx_data_hold", 32'(tx_data), 32'(held_byte));
    check_eq("grant_id_hold", 32'(grant_id), 32'(cur_g));
    if (tx_start) begin
      txlog.push_back(tx_data);
      n_starts++;
    end
    if (|req_ready) n_ready++;
    if (msg_abort) abort_seen = 1'b1;
    hs_q    = req_valid & req_ready;
    pend_hs = |hs_q;
    if (pend_hs) begin
      held_byte      = req_data[cur_g*W +: W];
      last_sent_last = req_last[cur_g];
    end
    start_seen = tx_start;
    prev_ga    = grant_active;
    prev_valid = req_valid;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_idle(input string tag, input int bound);
    int c = 0;
    do begin
      step();
      c++;
    end while (!(total_queued() == 0 && !grant_active && busy_cnt == 0 && !pend_hs) && c < bound);
    check_eq({tag, "_drained"}, 32'(total_queued()), 32'(0));
    check_eq({tag, "_idle"}, 32'(grant_active), 32'(0));
  endtask

  task automatic check_order(input string tag, input int exp_q[$]);
    check_eq({tag, "_count"}, 32'(gorder.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < gorder.size(); k++)
      check_eq({tag, "_order"}, 32'(gorder[k]), 32'(exp_q[k]));
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_start"}, 32'(tx_start), 32'(0));
    check_eq({tag, "_data"}, 32'(tx_data), 32'(0));
    check_eq({tag, "_ready"}, 32'(req_ready), 32'(0));
    check_eq({tag, "_active"}, 32'(grant_active), 32'(0));
    check_eq({tag, "_gid"}, 32'(grant_id), 32'(0));
    check_eq({tag, "_abort"}, 32'(msg_abort), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] hi_bytes [3];
    int c;
    hi_bytes = '{8'h48, 8'h69, 8'h0A};
    rst = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
    max_gap = 0; n_starts = 0; n_ready = 0; abort_seen = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    drive();

    // All four requesters with 2-byte messages
    for (int r = 0; r < N; r++) push_msg(r, 2);
    gorder.delete();
    run_idle("rr", 1000);
    check_order("rr", '{0, 1, 2, 3});

    // Single requester sends "Hi\n"
    gorder.delete();
    txlog.delete();
    push_byte(1, 8'h48, 1'b0);
    push_byte(1, 8'h69, 1'b0);
    push_byte(1, 8'h0A, 1'b1);
    run_idle("hi", 500);
    check_order("hi", '{1});
    check_eq("hi_bytes", 32'(txlog.size()), 32'(3));
    for (int k = 0; k < 3 && k < txlog.size(); k++) check_eq("hi_byte", 32'(txlog[k]), 32'(hi_bytes[k]));

    // Finishing requester drops to lowest priority, but is re-granted when alone
    gorder.delete();
    push_msg(2, 2);
    c = 0;
    while (!grant_active && c < 20) begin
      step();
      c++;
    end
    push_msg(0, 1);
    push_msg(2, 1);
    run_idle("fair", 1000);
    check_order("fair", '{2, 0, 2});
    gorder.delete();
    push_msg(2, 1);
    push_msg(2, 1);
    run_idle("regrant", 1000);
    check_order("regrant", '{2, 2});

    // Mid-message stall triggers the idle timeout
    gorder.delete();
    abort_seen = 1'b0;
    push_byte(3, 8'hC3, 1'b0);
    c = 0;
    while (!frame_end_now && c < 60) begin
      step();
      c++;
    end
    c = 0;
    do begin
      step();
      c++;
    end while (!abort_seen && c < 30);
    check_eq("abort_latency", 32'(c), 32'(2 + TO));
    check_order("stall", '{3});
    gorder.delete();
    push_msg(2, 1);
    push_msg(0, 1);
    run_idle("after_abort", 1000);
    check_order("after_abort", '{0, 2});

    // Transmitter held busy before a grant
    force_busy = 1'b1;
    n_starts = 0;
    n_ready = 0;
    push_msg(1, 2);
    repeat (15) step();
    check_eq("busy_starts", 32'(n_starts), 32'(0));
    check_eq("busy_ready", 32'(n_ready), 32'(0));
    check_eq("busy_granted", 32'(grant_active), 32'(1));
    force_busy = 1'b0;
    run_idle("busy_release", 500);

    // Randomized traffic
    max_gap = 4;
    for (int r = 0; r < N; r++) begin
      int nm = $urandom_range(3, 5);
      for (int m = 0; m < nm; m++) push_msg(r, $urandom_range(1, 4));
    end
    run_idle("random", 20000);
    max_gap = 0;

    // Asynchronous reset during WAIT_LO, with the pointer left away from zero
    push_msg(1, 1);
    run_idle("pre_reset", 500);
    push_msg(2, 2);
    c = 0;
    while (!(grant_active && tx_busy) && c < 40) begin
      step();
      c++;
    end
    step();
    #3;
    rst = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    model_reset();
    req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    gorder.delete();
    push_msg(3, 1);
    push_msg(1, 1);
    drive();
    run_idle("post_reset", 1000);
    check_order("post_reset", '{1, 3});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte-stream requesters, e.g. banner generator, status reporter and debug dump.
- Grants round-robin per message, not per byte. The grant is held from the first byte to the byte flagged last, so messages never interleave on ser_out.
- Sequences the transmitter through its start/busy handshake.
- Sits between requester blocks and the UART TX state machine/shifter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width.
- IDLE_TO, 255, cycles a granted requester may hold valid low mid-message before the grant is aborted; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*DATA_W  bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  byte is the final byte of its message.
- req_ready  out  NUM_REQ  byte accepted when valid & ready.
- tx_data  out  DATA_W  byte to the UART shifter.
- tx_start  out  1  one-cycle pulse that launches a frame.
- tx_busy  in  1  UART frame in flight (start, data and stop bits).
- grant_active  out  1  a message is in progress.
- grant_id  out  3  index of the current or last granted requester.
- msg_abort  out  1  one-cycle pulse when a grant is dropped by timeout.

Behaviour:
- Reset (async, immediate):
  - state IDLE.
  - tx_start 0, tx_data 0, req_ready 0, grant_active 0, grant_id 0, msg_abort 0.
  - rr pointer set so requester 0 has highest priority first.
  - Reset mid-frame drops tx_start and the grant at once. No resume after reset.
- States: IDLE, SEND, START, WAIT_HI, WAIT_LO.
- IDLE:
  - If any req_valid is set, select the first set bit searching from ptr upward, mod NUM_REQ.
  - Register grant_id and set grant_active=1 on that edge; next state SEND.
  - No valid: stay in IDLE.
- SEND:
  - req_ready[grant_id] is combinational: (state==SEND) & ~tx_busy. All other req_ready bits are 0 in every state.
  - On req_valid[g] & req_ready[g]: latch req_data[g] into tx_data, latch last_flag=req_last[g], clear the idle counter, go to START.
  - If req_valid[g] is low, the idle counter increments each cycle.
  - When the idle counter reaches IDLE_TO (IDLE_TO≠0): pulse msg_abort, clear grant_active, set ptr=g+1, go to IDLE.
  - Valid from other requesters is ignored while a grant is held.
- START: tx_start=1 for exactly this cycle, tx_data stable; next state WAIT_HI.
- WAIT_HI: wait until tx_busy=1, then go to WAIT_LO. No timeout.
- WAIT_LO:
  - Wait until tx_busy=0.
  - Then if last_flag: clear grant_active, ptr=g+1 mod NUM_REQ, go to IDLE.
  - Otherwise go back to SEND with the same grant.
- Latency:
  - Valid in IDLE → handshake possible in SEND on the next cycle.
  - Handshake → tx_start the following cycle.
  - End of frame (busy falls) → next byte ready for handshake 1 cycle later.
- Constraints:
  - tx_data changes only on a handshake and holds through the frame.
  - tx_start is never asserted while tx_busy=1.
- Simultaneous events:
  - The last byte and new requests arriving in the same cycle are resolved by the rr pointer in the following IDLE cycle.
  - The requester that just finished has lowest priority.
  - If it is the only one valid, it is re-granted.
  - An idle-counter expiry in the same cycle as a handshake: the handshake wins, no abort.
- grant_id holds its last value while idle.

Test Plan:
- Single requester:
  - Stimulus: req 1 sends "Hi\n" (0x48, 0x69, 0x0A; last on 0x0A); a UART model holds busy for 10 cycles per byte.
  - Required: three tx_start pulses with tx_data 0x48, 0x69, 0x0A; grant_id=1 throughout; grant_active falls one cycle after busy falls following 0x0A.
- Round-robin:
  - Stimulus: all four requesters valid with 2-byte messages.
  - Required: grant order 0,1,2,3; bytes never interleave; grant_active stays high across each message.
- Fairness after release:
  - Stimulus: req 2 completes its message while req 2 and req 0 are both valid.
  - Required: next grant_id=0. With only req 2 valid, it is re-granted.
- Mid-message stall:
  - Stimulus: IDLE_TO=5; req 3 sends 1 byte with last=0, then drops valid.
  - Required: msg_abort pulses exactly 5 cycles after SEND is re-entered; state returns to IDLE; next search starts at 0.
- Handshake discipline:
  - Stimulus: hold tx_busy=1 externally before a grant.
  - Required: req_ready stays 0 and tx_start never pulses until busy falls.
- Async reset:
  - Stimulus: assert rst during WAIT_LO of a message byte.
  - Required: all outputs zero in the same cycle; after release, the first grant goes to the lowest-index valid requester.
